// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory: assembles little-endian bytes into
// 32-bit words and writes them to consecutive word addresses starting at 0.
module imem_loader #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     byte_last,
  output logic                     byte_ready,
  output logic                     we,
  output logic [31:0]              wa,
  output logic [31:0]              wd,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   words
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [1:0]    lane_q,  lane_d;
  logic [31:0]   asm_q,   asm_d;
  logic [AW:0]   words_q, words_d;
  logic          last_q,  last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      words_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      words_q <= words_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    words_d = words_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RECV;
          index_d = '0;
          lane_d  = '0;
          asm_d   = '0;
          words_d = '0;
          last_d  = 1'b0;
        end
      end
      S_RECV: begin
        if (byte_valid) begin
          asm_d[8*lane_q +: 8] = byte_data;
          lane_d = lane_q + 2'd1;
          last_d = byte_last;
          if (lane_q == 2'd3 || byte_last) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        index_d = index_q + 1'b1;
        words_d = words_q + 1'b1;
        lane_d  = '0;
        asm_d   = '0;
        // Memory full ends the load just like an explicit last byte.
        if (last_q || index_q == AW'(DEPTH - 1)) state_d = S_DONE;
        else                                      state_d = S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == S_RECV);
    we         = (state_q == S_WRITE);
    busy       = (state_q == S_RECV) || (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    words      = words_q;
    wa         = '0;
    wd         = '0;
    if (state_q == S_WRITE) begin
      wa = 32'({index_q, 2'b00});
      wd = asm_q;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-list word model.
module tb_imem_loader;

  localparam int DEPTH = 32;
  localparam int WW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid, byte_last;
  logic [7:0]    byte_data;
  logic          byte_ready, we, busy, done;
  logic [31:0]   wa, wd;
  logic [WW-1:0] words;

  int checks   = 0;
  int failures = 0;

  logic [31:0] cap_wa[$];
  logic [31:0] cap_wd[$];

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .we(we), .wa(wa), .wd(wd),
    .busy(busy), .done(done), .words(words)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      cap_wa.push_back(wa);
      cap_wd.push_back(wd);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 0);
    check({tag, "_we"},    32'(we),         0);
    check({tag, "_wa"},    wa,              0);
    check({tag, "_wd"},    wd,              0);
    check({tag, "_busy"},  32'(busy),       0);
    check({tag, "_done"},  32'(done),       0);
    check({tag, "_words"}, 32'(words),      0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", 32'(byte_ready), 1);
    check("busy_after_start",  32'(busy),       1);
    check("done_after_start",  32'(done),       0);
    check("words_after_start", 32'(words),      0);
  endtask

  // Reference: group bytes four at a time (LSB first), close early on last, stop when memory is full.
  task automatic run_load(input logic [7:0] q[$], input bit has_last, input bit gaps, input bit pokes);
    logic [31:0] exp_w[$];
    logic [31:0] w;
    int exp_acc, lane, acc, wcount;
    bit pend_we, pend_done, final_word, finished, lastflag, valid;

    w = '0; lane = 0; exp_acc = 0;
    foreach (q[i]) begin
      if (exp_w.size() == DEPTH) break;
      w = w | (32'(q[i]) << (8 * lane));
      lane++;
      exp_acc++;
      if (lane == 4 || (has_last && i == q.size() - 1)) begin
        exp_w.push_back(w);
        w = '0;
        lane = 0;
      end
    end

    cap_wa.delete();
    cap_wd.delete();
    pulse_start();

    acc = 0; wcount = 0; pend_we = 0; pend_done = 0; final_word = 0; finished = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (pend_done) begin
        check("done_rise", 32'(done), 1);
        finished = 1;
        break;
      end
      if (pend_we) begin
        check("we_pulse", 32'(we), 1);
        pend_we = 0;
        if (final_word) pend_done = 1;
      end
      valid      = (acc < q.size()) && (!gaps || ($urandom_range(0, 1) == 1));
      lastflag   = has_last && (acc == q.size() - 1);
      byte_valid = valid;
      byte_data  = valid ? q[acc] : 8'($urandom);
      byte_last  = valid ? lastflag : 1'($urandom);
      start      = pokes && busy && ($urandom_range(0, 3) == 0);
      if (valid && byte_ready) begin
        acc++;
        if ((acc % 4 == 0) || lastflag) begin
          wcount++;
          pend_we    = 1;
          final_word = lastflag || (wcount == DEPTH);
        end
      end
      @(negedge clk);
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (!finished) check("load_timeout", 0, 1);

    check("nwrites",  32'(cap_wd.size()), 32'(exp_w.size()));
    foreach (exp_w[i]) begin
      if (i < cap_wd.size()) begin
        check("wa", cap_wa[i], 32'(i * 4));
        check("wd", cap_wd[i], exp_w[i]);
      end
    end
    check("accepted", 32'(acc), 32'(exp_acc));
    check("words",    32'(words), 32'(exp_w.size()));
    check("busy_end", 32'(busy), 0);

    // Surplus bytes after completion must be held off.
    if (acc < q.size()) begin
      for (int k = 0; k < 4; k++) begin
        byte_valid = 1'b1;
        byte_data  = q[acc];
        check("hold_off_ready", 32'(byte_ready), 0);
        @(negedge clk);
      end
      byte_valid = 1'b0;
      check("hold_off_done",  32'(done), 1);
      check("hold_off_words", 32'(words), 32'(DEPTH));
    end
  endtask

  task automatic reset_mid_word();
    int acc;
    logic [7:0] b0, b1, b2, b3;
    cap_wa.delete();
    cap_wd.delete();
    pulse_start();
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    acc = 0;
    for (int cyc = 0; cyc < 100 && acc < 6; cyc++) begin
      byte_valid = 1'b1;
      byte_last  = 1'b0;
      case (acc)
        0: byte_data = b0;
        1: byte_data = b1;
        2: byte_data = b2;
        3: byte_data = b3;
        default: byte_data = 8'($urandom);
      endcase
      if (byte_ready) acc++;
      @(negedge clk);
    end
    check("rst_fed", 32'(acc), 6);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("rst_mid");
    repeat (3) @(negedge clk);
    check("rst_nwrites", 32'(cap_wd.size()), 1);
    if (cap_wd.size() > 0) begin
      check("rst_wa0", cap_wa[0], 0);
      check("rst_wd0", cap_wd[0], {b3, b2, b1, b0});
    end
  endtask

  initial begin
    logic [7:0] q[$];
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(q, 1, 0, 0);
    if (cap_wd.size() == 2) begin
      check("tp_w0", cap_wd[0], 32'h12345678);
      check("tp_w1", cap_wd[1], 32'hDEADBEEF);
      check("tp_a1", cap_wa[1], 32'h4);
    end

    q = '{8'h11, 8'h22, 8'h33};
    run_load(q, 1, 0, 0);
    if (cap_wd.size() == 1) check("tp_partial", cap_wd[0], 32'h00332211);

    q.delete();
    for (int i = 0; i < 132; i++) q.push_back(8'($urandom));
    run_load(q, 0, 0, 0);

    q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(q, 1, 1, 1);

    reset_mid_word();
    q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    run_load(q, 1, 1, 0);

    for (int n = 0; n < 10; n++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) q.push_back(8'($urandom));
      run_load(q, 1, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
